// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart TX path among N byte-stream requesters, message-locked.
// Optional idle-grant timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned IDX_W   = 2,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req_valid,
   input  logic [N*8-1:0]   req_data,
   input  logic [N-1:0]     req_last,
   output logic [N-1:0]     req_ready,
   output logic             wr_uart,
   output logic [7:0]       w_data,
   input  logic             tx_full,
   output logic             busy,
   output logic [IDX_W-1:0] grant,
   output logic             timeout_err
);

   typedef enum logic {StIdle, StLock} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] pick;
   logic             pick_found;
   logic             owner_valid;
   logic             accept;

`ifdef UART_ARB_TIMEOUT_EN
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             timeout_err_q, timeout_err_d;
`endif

   // Circular search for the first valid requester after the last owner.
   always_comb begin
      logic [IDX_W-1:0] cand;
      pick       = '0;
      pick_found = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = IDX_W'((32'(ptr_q) + k) % N);
         if (!pick_found && req_valid[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   assign owner_valid = req_valid[grant_q];
   assign w_data      = req_data[{grant_q, 3'b000} +: 8];

   always_comb begin
      req_ready = '0;
      wr_uart   = 1'b0;
      if (state_q == StLock && !tx_full) begin
         req_ready[grant_q] = 1'b1;
         wr_uart            = owner_valid;
      end
   end

   assign accept = wr_uart;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_d      = to_cnt_q;
      timeout_err_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d = pick;
               state_d = StLock;
`ifdef UART_ARB_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
         end
         StLock: begin
            if (accept) begin
`ifdef UART_ARB_TIMEOUT_EN
               to_cnt_d = '0;
`endif
               if (req_last[grant_q]) begin
                  state_d = StIdle;
                  ptr_d   = grant_q;
               end
            end
`ifdef UART_ARB_TIMEOUT_EN
            // A stalled but valid owner (tx_full) holds the counter.
            else if (to_cnt_q == TO_W'(TIMEOUT)) begin
               state_d       = StIdle;
               ptr_d         = grant_q;
               timeout_err_d = 1'b1;
            end else if (!owner_valid) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         ptr_q   <= IDX_W'(N - 1);
`ifdef UART_ARB_TIMEOUT_EN
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign busy  = (state_q == StLock);
   assign grant = grant_q;

`ifdef UART_ARB_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`else
   logic unused_cfg;
   assign unused_cfg  = ^{TIMEOUT[0], TO_W[0]};
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// scored against a message-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*8-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           wr_uart;
   logic [7:0]     w_data;
   logic           tx_full;
   logic           busy;
   logic [1:0]     grant;
   logic           timeout_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: pending messages per requester and the expected write stream.
   logic [7:0] q_byte[N][$];
   bit         q_last[N][$];
   logic [7:0] exp_byte[$];
   int         exp_src[$];
   bit         exp_last[$];
   int         m_ptr;

   uart_tx_arbiter #(.N(N), .IDX_W(2), .TIMEOUT(4), .TO_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .wr_uart     (wr_uart),
      .w_data      (w_data),
      .tx_full     (tx_full),
      .busy        (busy),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      tx_full   = 1'b0;
      step();
      step();
      reset = 1'b0;
      m_ptr = N - 1;
   endtask

   task automatic add_msg(input int src, input int len);
      for (int j = 0; j < len; j++) begin
         q_byte[src].push_back(8'($urandom));
         q_last[src].push_back(j == len - 1);
      end
   endtask

   // Whole messages granted round-robin among requesters that still have messages.
   task automatic build_expected();
      int  cur[N];
      int  rem[N];
      int  pick;
      bit  found;
      exp_byte.delete();
      exp_src.delete();
      exp_last.delete();
      for (int i = 0; i < N; i++) begin
         cur[i] = 0;
         rem[i] = 0;
         for (int j = 0; j < q_last[i].size(); j++) if (q_last[i][j]) rem[i]++;
      end
      while (1) begin
         found = 0;
         pick  = 0;
         for (int k = 1; k <= N; k++) begin
            if (!found && rem[(m_ptr + k) % N] > 0) begin
               pick  = (m_ptr + k) % N;
               found = 1;
            end
         end
         if (!found) break;
         while (1) begin
            exp_byte.push_back(q_byte[pick][cur[pick]]);
            exp_src.push_back(pick);
            exp_last.push_back(q_last[pick][cur[pick]]);
            cur[pick]++;
            if (q_last[pick][cur[pick] - 1]) break;
         end
         rem[pick]--;
         m_ptr = pick;
      end
   endtask

   task automatic run_engine(input int gap_max, input bit rand_full, input string name);
      int         gap[N];
      bit         acc[N];
      bit         prev_last;
      int         ei;
      int         cyc;
      logic [N-1:0] exp_rdy;
      ei = 0;
      prev_last = 0;
      cyc = 0;
      for (int i = 0; i < N; i++) gap[i] = 0;
      while (ei < exp_byte.size() && cyc < 2000) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && q_byte[i].size() > 0) begin
               if (gap[i] > 0) gap[i]--;
               else begin
                  req_valid[i]       = 1'b1;
                  req_data[i*8 +: 8] = q_byte[i][0];
                  req_last[i]        = q_last[i][0];
               end
            end
         end
         tx_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
         @(negedge clk);
         if (prev_last) begin
            n_checks++;
            if (busy !== 1'b0 || wr_uart !== 1'b0)
               $display("FAIL %s bubble: busy=%b wr_uart=%b, required 0 0", name, busy, wr_uart);
            else n_pass++;
         end
         prev_last = 0;
         for (int i = 0; i < N; i++) acc[i] = req_valid[i] && req_ready[i];
         if (wr_uart) begin
            n_checks++;
            if (ei >= exp_byte.size()) begin
               $display("FAIL %s extra write: w_data=%h, required no write", name, w_data);
            end else begin
               if (w_data !== exp_byte[ei])
                  $display("FAIL %s byte %0d: w_data=%h, required %h", name, ei, w_data,
                           exp_byte[ei]);
               else n_pass++;
               exp_rdy = '0;
               exp_rdy[exp_src[ei]] = 1'b1;
               n_checks++;
               if (req_ready !== exp_rdy)
                  $display("FAIL %s owner %0d: req_ready=%b, required %b", name, ei, req_ready,
                           exp_rdy);
               else n_pass++;
               prev_last = exp_last[ei];
               ei++;
            end
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               gap[i] = q_last[i][0] ? 0 : $urandom_range(0, gap_max);
               void'(q_byte[i].pop_front());
               void'(q_last[i].pop_front());
               req_valid[i] = 1'b0;
            end
         end
         cyc++;
      end
      tx_full = 1'b0;
      n_checks++;
      if (ei !== exp_byte.size())
         $display("FAIL %s completion: bytes written=%0d, required %0d", name, ei,
                  exp_byte.size());
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || wr_uart !== 1'b0)
         $display("FAIL %s final idle: busy=%b wr_uart=%b, required 0 0", name, busy, wr_uart);
      else n_pass++;
      step();
   endtask

   task automatic test_reset();
      logic [7:0] exp_w;
      req_data  = N*8'($urandom);
      exp_w     = req_data[7:0];
      reset     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      tx_full   = 1'b0;
      step();
      @(negedge clk);
      n_checks++;
      if (wr_uart !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0)
         $display("FAIL reset ctrl: wr=%b rdy=%b busy=%b, required 0 0000 0", wr_uart,
                  req_ready, busy);
      else n_pass++;
      n_checks++;
      if (grant !== 2'd0 || timeout_err !== 1'b0)
         $display("FAIL reset grant: grant=%0d terr=%b, required 0 0", grant, timeout_err);
      else n_pass++;
      n_checks++;
      if (w_data !== exp_w) $display("FAIL reset w_data: %h, required %h", w_data, exp_w);
      else n_pass++;
      step();
      reset = 1'b0;
      m_ptr = N - 1;
   endtask

   task automatic test_solo();
      do_reset();
      req_data[23:16] = 8'h41;
      req_last[2]     = 1'b0;
      req_valid[2]    = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wr_uart !== 1'b0) $display("FAIL solo idle write: wr_uart=%b, required 0", wr_uart);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if (wr_uart !== 1'b1 || w_data !== 8'h41 || req_ready !== 4'b0100)
         $display("FAIL solo byte1: wr=%b data=%h rdy=%b, required 1 41 0100", wr_uart,
                  w_data, req_ready);
      else n_pass++;
      step();
      req_data[23:16] = 8'h42;
      req_last[2]     = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wr_uart !== 1'b1 || w_data !== 8'h42)
         $display("FAIL solo byte2: wr=%b data=%h, required 1 42", wr_uart, w_data);
      else n_pass++;
      step();
      req_valid[2] = 1'b0;
      req_last[2]  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || grant !== 2'd2)
         $display("FAIL solo end: busy=%b grant=%0d, required 0 2", busy, grant);
      else n_pass++;
      step();
   endtask

   task automatic test_simultaneous_and_wrap();
      do_reset();
      add_msg(0, 2);
      add_msg(1, 2);
      add_msg(3, 2);
      build_expected();
      run_engine(0, 0, "simultaneous");
      add_msg(0, 2);
      add_msg(3, 2);
      build_expected();
      run_engine(0, 0, "wrap");
   endtask

   task automatic test_backpressure();
      logic [7:0] b[4];
      do_reset();
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
      req_data[15:8] = b[0];
      req_last[1]    = 1'b0;
      req_valid[1]   = 1'b1;
      @(negedge clk);
      step();
      for (int k = 0; k < 4; k++) begin
         if (k == 2) begin
            tx_full = 1'b1;
            repeat (5) begin
               @(negedge clk);
               n_checks++;
               if (wr_uart !== 1'b0 || req_ready !== 4'b0 || w_data !== b[2])
                  $display("FAIL backpressure stall: wr=%b rdy=%b data=%h, required 0 0000 %h",
                           wr_uart, req_ready, w_data, b[2]);
               else n_pass++;
               step();
            end
            tx_full = 1'b0;
         end
         @(negedge clk);
         n_checks++;
         if (wr_uart !== 1'b1 || w_data !== b[k])
            $display("FAIL backpressure byte %0d: wr=%b data=%h, required 1 %h", k, wr_uart,
                     w_data, b[k]);
         else n_pass++;
         step();
         if (k < 3) begin
            req_data[15:8] = b[k+1];
            req_last[1]    = (k + 1 == 3);
         end
      end
      req_valid[1] = 1'b0;
      req_last[1]  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL backpressure end: busy=%b, required 0", busy);
      else n_pass++;
      step();
   endtask

   task automatic test_timeout();
      int         pulses;
      bit         seen_wr;
      logic [7:0] first_data;
      logic [N-1:0] first_rdy;
      pulses  = 0;
      seen_wr = 0;
      first_data = '0;
      first_rdy  = '0;
      do_reset();
      req_data[15:8] = 8'h55;
      req_last[1]    = 1'b0;
      req_valid[1]   = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      n_checks++;
      if (wr_uart !== 1'b1 || w_data !== 8'h55)
         $display("FAIL timeout first byte: wr=%b data=%h, required 1 55", wr_uart, w_data);
      else n_pass++;
      step();
      req_valid[1]    = 1'b0;
      req_data[23:16] = 8'h66;
      req_last[2]     = 1'b1;
      req_valid[2]    = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (timeout_err === 1'b1) pulses++;
         if (wr_uart === 1'b1 && !seen_wr) begin
            seen_wr    = 1;
            first_data = w_data;
            first_rdy  = req_ready;
         end
         step();
         if (seen_wr) req_valid[2] = 1'b0;
      end
`ifdef UART_ARB_TIMEOUT_EN
      n_checks++;
      if (pulses !== 1) $display("FAIL timeout pulses: %0d, required 1", pulses);
      else n_pass++;
      n_checks++;
      if (!seen_wr || first_data !== 8'h66 || first_rdy !== 4'b0100)
         $display("FAIL timeout regrant: wr=%b data=%h rdy=%b, required 1 66 0100", seen_wr,
                  first_data, first_rdy);
      else n_pass++;
`else
      n_checks++;
      if (pulses !== 0 || seen_wr) $display("FAIL no-timeout hold: pulses=%0d wr=%b, required 0 0",
                                            pulses, seen_wr);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL no-timeout busy: %b, required 1", busy);
      else n_pass++;
`endif
      req_valid = '0;
      req_last  = '0;
      step();
   endtask

   task automatic test_mid_reset();
      do_reset();
      req_data[31:24] = 8'hA0;
      req_last[3]     = 1'b0;
      req_valid[3]    = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      step();
      req_data[31:24] = 8'hA1;
      reset           = 1'b1;
      @(negedge clk);
      step();
      reset          = 1'b0;
      req_data[31:24] = 8'hA2;
      req_data[7:0]  = 8'h77;
      req_last[0]    = 1'b1;
      req_valid[0]   = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wr_uart !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 || grant !== 2'd0 ||
          timeout_err !== 1'b0)
         $display("FAIL mid-reset outputs: wr=%b rdy=%b busy=%b grant=%0d terr=%b, required 0",
                  wr_uart, req_ready, busy, grant, timeout_err);
      else n_pass++;
      n_checks++;
      if (w_data !== 8'h77) $display("FAIL mid-reset w_data: %h, required 77", w_data);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if (wr_uart !== 1'b1 || req_ready !== 4'b0001 || w_data !== 8'h77)
         $display("FAIL mid-reset regrant: wr=%b rdy=%b data=%h, required 1 0001 77", wr_uart,
                  req_ready, w_data);
      else n_pass++;
      step();
      req_valid = '0;
      req_last  = '0;
      step();
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int i = 0; i < N; i++) begin
            int nm;
            nm = $urandom_range(0, 3);
            for (int m = 0; m < nm; m++) add_msg(i, $urandom_range(1, 4));
         end
         build_expected();
         run_engine(2, 1, "random");
      end
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_full   = 1'b0;
      m_ptr     = N - 1;
      test_reset();
      test_solo();
      test_simultaneous_and_wrap();
      test_backpressure();
      test_timeout();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
